fifo_in_arb_ctrl: RTL and testbench

//  Sequencer and arbiter for the 8-entry input FIFO of the factorial machine.
//  - Shares the FIFO write port between two requesters, using round-robin.
//  - Serves one reader.
//  - Keeps a shadow occupancy count.
//  - Issues one registered 3-bit op code per cycle that drives the FIFO pointer/count logic.

---
 rtl/fifo_in_arb_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_in_arb_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_in_arb_ctrl.sv
// Write-port arbiter, read sequencer and shadow occupancy counter for the input FIFO.
// Optional saturating error counters are enabled with the FIFO_ARB_ERRCNT_EN macro.
module fifo_in_arb_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        wr_req,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              rd_req,
   output logic [1:0]        wr_gnt,
   output logic              rd_gnt,
   output logic [2:0]        state,
   output logic [DATA_W-1:0] fifo_din,
   output logic [CNT_W-1:0]  occ,
   output logic              wr_err,
   output logic              rd_err
`ifdef FIFO_ARB_ERRCNT_EN
   ,
   output logic [7:0]        wr_err_cnt,
   output logic [7:0]        rd_err_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      WRITE    = 3'b001,
      READ     = 3'b010,
      WR_ERROR = 3'b011,
      RD_ERROR = 3'b100
   } op_t;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   op_t  op_q, op_d;
   logic prio_rd;
   logic rr_last;
   logic sel;
   logic contested;
   logic any_wr;

   assign state  = op_q;
   assign any_wr = |wr_req;

   always_comb begin
      op_d      = IDLE;
      sel       = wr_req[1];
      contested = 1'b0;
      wr_gnt    = '0;
      rd_gnt    = 1'b0;
      // Round-robin only matters when both sources request.
      if (wr_req == 2'b11) sel = ~rr_last;
      if (any_wr && rd_req) begin
         contested = 1'b1;
         if (occ == '0)        op_d = WRITE;
         else if (occ == FULL) op_d = READ;
         else                  op_d = prio_rd ? READ : WRITE;
      end else if (any_wr) begin
         op_d = (occ != FULL) ? WRITE : WR_ERROR;
      end else if (rd_req) begin
         op_d = (occ != '0) ? READ : RD_ERROR;
      end
      if (op_d == WRITE) wr_gnt = sel ? 2'b10 : 2'b01;
      rd_gnt = (op_d == READ);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= IDLE;
         occ      <= '0;
         fifo_din <= '0;
         wr_err   <= 1'b0;
         rd_err   <= 1'b0;
         prio_rd  <= 1'b0;
         rr_last  <= 1'b1;
      end else begin
         op_q   <= op_d;
         wr_err <= (op_d == WR_ERROR);
         rd_err <= (op_d == RD_ERROR);
         if (contested) prio_rd <= ~prio_rd;
         case (op_d)
            WRITE: begin
               occ      <= occ + CNT_W'(1);
               fifo_din <= sel ? wr_data1 : wr_data0;
               rr_last  <= sel;
            end
            READ:    occ <= occ - CNT_W'(1);
            default: ;
         endcase
      end
   end

`ifdef FIFO_ARB_ERRCNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_err_cnt <= '0;
         rd_err_cnt <= '0;
      end else begin
         if (op_d == WR_ERROR && wr_err_cnt != '1) wr_err_cnt <= wr_err_cnt + 8'd1;
         if (op_d == RD_ERROR && rd_err_cnt != '1) rd_err_cnt <= rd_err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_in_arb_ctrl.sv
// Scoreboard bench for fifo_in_arb_ctrl: the driver queues hand-computed expectations,
// the monitor checks grants before each edge and registered outputs after it.
module tb_fifo_in_arb_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  wr_req;
   logic [31:0] wr_data0, wr_data1;
   logic        rd_req;
   logic [1:0]  wr_gnt;
   logic        rd_gnt;
   logic [2:0]  state;
   logic [31:0] fifo_din;
   logic [3:0]  occ;
   logic        wr_err, rd_err;
`ifdef FIFO_ARB_ERRCNT_EN
   logic [7:0]  wr_err_cnt, rd_err_cnt;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]  gnt;
      logic        rgnt;
      logic [2:0]  st;
      logic [31:0] din;
      logic [3:0]  occ;
      logic        we;
      logic        re;
   } exp_t;

   exp_t q[$];

   fifo_in_arb_ctrl #(.DATA_W(32), .DEPTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .wr_data0(wr_data0),
      .wr_data1(wr_data1), .rd_req(rd_req), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt),
      .state(state), .fifo_din(fifo_din), .occ(occ), .wr_err(wr_err), .rd_err(rd_err)
`ifdef FIFO_ARB_ERRCNT_EN
      , .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] wq, input logic rq, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] eg, input logic erg,
                       input logic [2:0] es, input logic [31:0] ed, input logic [3:0] eo,
                       input logic ewe, input logic ere);
      exp_t e;
      @(negedge clk);
      wr_req = wq; rd_req = rq; wr_data0 = d0; wr_data1 = d1;
      e.gnt = eg; e.rgnt = erg; e.st = es; e.din = ed; e.occ = eo; e.we = ewe; e.re = ere;
      q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      wr_req = 2'b00; rd_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      wr_req = 2'b00; rd_req = 1'b0; reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("wr_gnt", 32'(wr_gnt), 32'(e.gnt));
            check("rd_gnt", 32'(rd_gnt), 32'(e.rgnt));
            @(posedge clk);
            #1;
            check("state", 32'(state), 32'(e.st));
            check("fifo_din", fifo_din, e.din);
            check("occ", 32'(occ), 32'(e.occ));
            check("wr_err", 32'(wr_err), 32'(e.we));
            check("rd_err", 32'(rd_err), 32'(e.re));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      reset_n = 1'b0; wr_req = 2'b00; rd_req = 1'b0; wr_data0 = '0; wr_data1 = '0;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_occ", 32'(occ), 32'd0);
      check("rst_din", fifo_din, 32'd0);
      check("rst_errs", {30'd0, wr_err, rd_err}, 32'd0);
      check("rst_gnt", {29'd0, wr_gnt, rd_gnt}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // single source write
      step(2'b01, 1'b0, 32'h5, 32'h0, 2'b01, 1'b0, 3'b001, 32'h5, 4'd1, 1'b0, 1'b0);
      idle();

      // round-robin from reset, then fill to full
      do_reset();
      step(2'b11, 1'b0, 32'hA, 32'hB, 2'b01, 1'b0, 3'b001, 32'hA, 4'd1, 1'b0, 1'b0);
      step(2'b11, 1'b0, 32'hA, 32'hB, 2'b10, 1'b0, 3'b001, 32'hB, 4'd2, 1'b0, 1'b0);
      step(2'b11, 1'b0, 32'hA, 32'hB, 2'b01, 1'b0, 3'b001, 32'hA, 4'd3, 1'b0, 1'b0);
      step(2'b11, 1'b0, 32'hA, 32'hB, 2'b10, 1'b0, 3'b001, 32'hB, 4'd4, 1'b0, 1'b0);
      step(2'b01, 1'b0, 32'hC, 32'hB, 2'b01, 1'b0, 3'b001, 32'hC, 4'd5, 1'b0, 1'b0);
      step(2'b01, 1'b0, 32'hC, 32'hB, 2'b01, 1'b0, 3'b001, 32'hC, 4'd6, 1'b0, 1'b0);
      step(2'b01, 1'b0, 32'hC, 32'hB, 2'b01, 1'b0, 3'b001, 32'hC, 4'd7, 1'b0, 1'b0);
      step(2'b01, 1'b0, 32'hC, 32'hB, 2'b01, 1'b0, 3'b001, 32'hC, 4'd8, 1'b0, 1'b0);
      // write into a full FIFO
      step(2'b01, 1'b0, 32'hD, 32'hB, 2'b00, 1'b0, 3'b011, 32'hC, 4'd8, 1'b1, 1'b0);
      step(2'b01, 1'b0, 32'hD, 32'hB, 2'b00, 1'b0, 3'b011, 32'hC, 4'd8, 1'b1, 1'b0);
      step(2'b00, 1'b0, 32'hD, 32'hB, 2'b00, 1'b0, 3'b000, 32'hC, 4'd8, 1'b0, 1'b0);
`ifdef FIFO_ARB_ERRCNT_EN
      check("wr_err_cnt", 32'(wr_err_cnt), 32'd2);
      check("rd_err_cnt0", 32'(rd_err_cnt), 32'd0);
`endif
      // contested at full must read
      step(2'b01, 1'b1, 32'hD, 32'hB, 2'b00, 1'b1, 3'b010, 32'hC, 4'd7, 1'b0, 1'b0);
      idle();

      // read from empty, then contested at empty must write
      do_reset();
      step(2'b00, 1'b1, 32'h7, 32'h0, 2'b00, 1'b0, 3'b100, 32'h0, 4'd0, 1'b0, 1'b1);
      step(2'b01, 1'b1, 32'h7, 32'h0, 2'b01, 1'b0, 3'b001, 32'h7, 4'd1, 1'b0, 1'b0);
      step(2'b00, 1'b0, 32'h7, 32'h0, 2'b00, 1'b0, 3'b000, 32'h7, 4'd1, 1'b0, 1'b0);
`ifdef FIFO_ARB_ERRCNT_EN
      check("rd_err_cnt", 32'(rd_err_cnt), 32'd1);
`endif

      // alternating priority in the middle of the range
      do_reset();
      step(2'b01, 1'b0, 32'h1, 32'h0, 2'b01, 1'b0, 3'b001, 32'h1, 4'd1, 1'b0, 1'b0);
      step(2'b01, 1'b0, 32'h2, 32'h0, 2'b01, 1'b0, 3'b001, 32'h2, 4'd2, 1'b0, 1'b0);
      step(2'b01, 1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 3'b001, 32'h3, 4'd3, 1'b0, 1'b0);
      step(2'b01, 1'b1, 32'h10, 32'h0, 2'b01, 1'b0, 3'b001, 32'h10, 4'd4, 1'b0, 1'b0);
      step(2'b01, 1'b1, 32'h11, 32'h0, 2'b00, 1'b1, 3'b010, 32'h10, 4'd3, 1'b0, 1'b0);
      step(2'b01, 1'b1, 32'h12, 32'h0, 2'b01, 1'b0, 3'b001, 32'h12, 4'd4, 1'b0, 1'b0);
      step(2'b01, 1'b1, 32'h13, 32'h0, 2'b00, 1'b1, 3'b010, 32'h12, 4'd3, 1'b0, 1'b0);

      // asynchronous reset while a request is pending
      step(2'b01, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 3'b001, 32'h21, 4'd4, 1'b0, 1'b0);
      @(negedge clk);
      wr_req = 2'b10; rd_req = 1'b0; wr_data1 = 32'h33;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_occ", 32'(occ), 32'd0);
      check("arst_din", fifo_din, 32'd0);
`ifdef FIFO_ARB_ERRCNT_EN
      check("arst_cnt", {16'd0, wr_err_cnt, rd_err_cnt}, 32'd0);
`endif
      @(negedge clk);
      wr_req = 2'b00;
      reset_n = 1'b1;
      step(2'b11, 1'b0, 32'h40, 32'h41, 2'b01, 1'b0, 3'b001, 32'h40, 4'd1, 1'b0, 1'b0);
      idle();

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
